maze_memory_ctrl: RTL and testbench
===================================

MAZE_MEMORY_CTRL -- requirements
Module: maze_memory_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port CLK, input, 1 bit, rising-edge clock for all state.
REQ-003 SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port X, input, 4 bits, maze column of the access.
REQ-005 SHALL have port Y, input, 4 bits, maze row of the access.
REQ-006 SHALL have port D_in, input, 1 bit, cell write data (1 = wall/visited).
REQ-007 SHALL have port RD, input, 1 bit, read request.
REQ-008 SHALL have port WR, input, 1 bit, write request.
REQ-009 SHALL have port D_out, output, 1 bit, registered cell read data.
REQ-010 SHALL have port Load_start, input, 1 bit, begin serial maze load.
REQ-011 SHALL have port Load_valid, input, 1 bit, Load_bit qualifier.
REQ-012 SHALL have port Load_bit, input, 1 bit, serial cell value.
REQ-013 SHALL have port Ready, output, 1 bit, high when RD/WR are served.
REQ-014 SHALL have port Load_done, output, 1 bit, one-cycle pulse at load completion.
REQ-015 SHALL have port Err, output, 1 bit, one-cycle pulse on a rejected access.

Function
REQ-016 SHALL store 256 x 1-bit cells, cell index = {Y,X} (8 bits).
REQ-017 SHALL implement states SCRUB, IDLE, LOAD; Ready = 1 only in IDLE.
REQ-018 SHALL, in IDLE with RD=1 and WR=0, load D_out with mem[{Y,X}] at the next edge (latency 1); D_out holds otherwise.
REQ-019 SHALL, in IDLE with WR=1, write D_in to mem[{Y,X}] at the edge; if RD=1 too, D_out also takes D_in (write-first).
REQ-020 SHALL, in IDLE with Load_start=1, enter LOAD with 8-bit counter = 0; Load_start has priority and any same-cycle RD/WR is ignored without Err.
REQ-021 SHALL, in LOAD, on each cycle with Load_valid=1, write Load_bit to mem[counter] and increment counter; Load_valid=0 cycles stall without effect.
REQ-022 SHALL, on the Load_valid write at counter = 255, return to IDLE, assert Load_done for exactly one cycle and set Ready the same edge; counter wraps to 0.
REQ-023 SHALL, on Load_start=1 while in LOAD, restart with counter = 0 (the same-cycle Load_bit is discarded).
REQ-024 SHALL, on RD or WR while Ready=0, leave memory and D_out unchanged and pulse Err for one cycle per requesting cycle.
REQ-025 SHALL ignore Load_valid/Load_bit in IDLE and SCRUB.

Reset
REQ-026 SHALL, on RST=1, immediately set D_out=0, Load_done=0, Err=0, counter=0, state=SCRUB (macro defined) or IDLE (macro undefined), and Ready accordingly.
REQ-027 SHALL abort an in-progress LOAD or SCRUB on reset; cells already written keep their values.
REQ-028 SHALL not reset the cell array itself.

Configuration
REQ-029 SHALL, with MAZE_MEM_SCRUB_EN defined, write 0 to mem[counter] each cycle in SCRUB for 256 cycles after reset release, then enter IDLE (Ready=1 on cycle 257); Load_start in SCRUB is ignored.
REQ-030 SHALL, without MAZE_MEM_SCRUB_EN, omit SCRUB, enter IDLE directly from reset, and leave cell contents undefined until written or loaded.

Verification
REQ-031 Serial load: Load_start, then 256 Load_valid bits with bit i = (i mod 3 == 0) -> Load_done pulses once after bit 255, Ready=1; RD at X=3,Y=0 -> D_out=1 one cycle later; RD at X=4,Y=0 -> D_out=0.
REQ-032 Write/read: WR with D_in=1, X=5, Y=9 then RD at same cell -> D_out=1; RD+WR with D_in=0 at same cell -> D_out=0 next edge.
REQ-033 Rejected access: RD=1 during LOAD at counter 40 -> Err=1 for one cycle, D_out unchanged, counter still advances on Load_valid.
REQ-034 Load stalls and restart: Load_valid low for 10 cycles mid-load -> counter unchanged; Load_start at counter 100 -> counter=0, Load_done only after 256 further valid bits.
REQ-035 Reset mid-load at counter 128 -> D_out=0, Ready per macro, Load_done never pulses; with MAZE_MEM_SCRUB_EN, Ready rises 256 cycles after RST release and RD at any cell returns 0.

Source files
------------

// File: rtl/maze_memory_ctrl.sv
// maze_memory_ctrl: 256 x 1-bit maze cell store with a host RD/WR port and a serial bulk loader.
// Optional feature: define MAZE_MEM_SCRUB_EN to zero the whole array after every reset release.
// Ports: CLK rising-edge clock, RST async active-high reset;
//   X/Y cell column/row, D_in write data, RD/WR host requests, D_out registered read data;
//   Load_start/Load_valid/Load_bit serial load stream;
//   Ready high while host accesses are served, Load_done and Err one-cycle pulses.
module maze_memory_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       D_in,
  input  logic       RD,
  input  logic       WR,
  output logic       D_out,
  input  logic       Load_start,
  input  logic       Load_valid,
  input  logic       Load_bit,
  output logic       Ready,
  output logic       Load_done,
  output logic       Err
);
  typedef enum logic [1:0] {SCRUB, IDLE, LOAD} state_t;
`ifdef MAZE_MEM_SCRUB_EN
  localparam state_t init_st = SCRUB;
`else
  localparam state_t init_st = IDLE;
`endif
  state_t state;
  logic [7:0] cnt, wa;
  logic mem [256];
  logic we, wd, idle_acc;
  // Load_start wins over a same-cycle host access, so the access is dropped rather than served.
  always_comb begin
    idle_acc = state == IDLE && !Load_start;
    we = !RST && ((idle_acc && WR) || (state == LOAD && Load_valid && !Load_start)
`ifdef MAZE_MEM_SCRUB_EN
      || state == SCRUB
`endif
      );
    wa = state == IDLE ? {Y, X} : cnt;
    wd = state == IDLE ? D_in : state == LOAD && Load_bit;
  end
  // The array is deliberately outside the reset domain so a reset keeps cell contents.
  always_ff @(posedge CLK)
    if (we) mem[wa] <= wd;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state     <= init_st;
      cnt       <= '0;
      D_out     <= 1'b0;
      Ready     <= init_st == IDLE;
      Load_done <= 1'b0;
      Err       <= 1'b0;
    end else begin
      Load_done <= 1'b0;
      Err       <= !Ready && (RD || WR);
      if (idle_acc && RD) D_out <= WR ? D_in : mem[{Y, X}];
      if (state == IDLE && Load_start) begin
        state <= LOAD;
        Ready <= 1'b0;
        cnt   <= '0;
      end else if (state == LOAD && Load_start) begin
        cnt <= '0;
      end else if ((state == LOAD && Load_valid) || state == SCRUB) begin
        cnt <= cnt + 8'd1;
        if (cnt == 8'hff) begin
          state     <= IDLE;
          Ready     <= 1'b1;
          Load_done <= state == LOAD;
        end
      end
    end
endmodule

// File: tb/tb_maze_memory_ctrl.sv
// tb_maze_memory_ctrl: directed self-checking bench for maze_memory_ctrl.
module tb_maze_memory_ctrl;
  logic CLK = 0, RST = 0, D_in = 0, RD = 0, WR = 0;
  logic Load_start = 0, Load_valid = 0, Load_bit = 0;
  logic [3:0] X = 0, Y = 0;
  logic D_out, Ready, Load_done, Err;
  int n_chk = 0, n_fail = 0, pulses;
`ifdef MAZE_MEM_SCRUB_EN
  localparam logic scrub = 1'b1;
`else
  localparam logic scrub = 1'b0;
`endif
  maze_memory_ctrl dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y), .D_in(D_in), .RD(RD), .WR(WR), .D_out(D_out),
    .Load_start(Load_start), .Load_valid(Load_valid), .Load_bit(Load_bit),
    .Ready(Ready), .Load_done(Load_done), .Err(Err)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic rd(input logic [3:0] x, input logic [3:0] y);
    X = x;
    Y = y;
    RD = 1;
    tick;
    RD = 0;
  endtask
  task automatic release_rst;
    RST = 0;
`ifdef MAZE_MEM_SCRUB_EN
    repeat (255) tick;
    chk("scrub_busy", Ready, 1'b0);
    tick;
`endif
    chk("ready_up", Ready, 1'b1);
  endtask
  initial begin
    #1 RST = 1;
    #2;
    chk("rst_dout", D_out, 1'b0);
    chk("rst_done", Load_done, 1'b0);
    chk("rst_err", Err, 1'b0);
    chk("rst_ready", Ready, !scrub);
    tick;
    tick;
    release_rst;
`ifdef MAZE_MEM_SCRUB_EN
    rd(5, 9);
    chk("scrub_zero", D_out, 1'b0);
`endif
    X = 5; Y = 9; D_in = 1; WR = 1;
    tick;
    WR = 0;
    chk("wr_err", Err, 1'b0);
    rd(5, 9);
    chk("rd_wr1", D_out, 1'b1);
    RD = 1; WR = 1; D_in = 0;
    tick;
    RD = 0; WR = 0;
    chk("rdwr_first0", D_out, 1'b0);
    rd(5, 9);
    chk("rd_after0", D_out, 1'b0);
    RD = 1; WR = 1; D_in = 1;
    tick;
    RD = 0; WR = 0;
    chk("rdwr_first1", D_out, 1'b1);
    Load_start = 1; RD = 1;
    tick;
    Load_start = 0; RD = 0;
    chk("start_noerr", Err, 1'b0);
    chk("start_dout", D_out, 1'b1);
    chk("start_ready", Ready, 1'b0);
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 60) begin
        Load_valid = 0;
        repeat (10) tick;
        chk("stall_ready", Ready, 1'b0);
        chk("stall_done", Load_done, 1'b0);
      end
      Load_valid = 1;
      Load_bit = (i % 3 == 0);
      RD = (i == 40);
      WR = (i == 41);
      tick;
      RD = 0; WR = 0;
      pulses += Load_done;
      if (i == 40) begin
        chk("rej_rd_err", Err, 1'b1);
        chk("rej_rd_dout", D_out, 1'b1);
      end
      if (i == 41) chk("rej_wr_err", Err, 1'b1);
      if (i == 42) chk("err_pulse_end", Err, 1'b0);
      if (i == 254) chk("ready_b4_last", Ready, 1'b0);
    end
    Load_valid = 0;
    chk("load_done", Load_done, 1'b1);
    chk("load_ready", Ready, 1'b1);
    chk("load_pulses", pulses == 1, 1'b1);
    tick;
    chk("done_one_cyc", Load_done, 1'b0);
    rd(3, 0);  chk("ld_c3", D_out, 1'b1);
    rd(4, 0);  chk("ld_c4", D_out, 1'b0);
    rd(15, 15); chk("ld_c255", D_out, 1'b1);
    rd(14, 15); chk("ld_c254", D_out, 1'b0);
    rd(7, 2);  chk("ld_c39", D_out, 1'b1);
    rd(8, 2);  chk("ld_c40", D_out, 1'b0);
    rd(5, 9);  chk("ld_c149", D_out, 1'b0);
    rd(0, 0);  chk("ld_c0", D_out, 1'b1);
    Load_start = 1;
    tick;
    Load_start = 0;
    for (int i = 0; i < 100; i++) begin
      Load_valid = 1; Load_bit = 1;
      tick;
    end
    Load_start = 1; Load_valid = 1; Load_bit = 1;
    tick;
    Load_start = 0;
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      Load_valid = 1;
      Load_bit = i[0];
      tick;
      pulses += Load_done;
      if (i == 155) chk("restart_busy", Ready, 1'b0);
    end
    Load_valid = 0;
    chk("restart_pulses", pulses == 1, 1'b1);
    chk("restart_ready", Ready, 1'b1);
    rd(0, 0);  chk("rs_c0", D_out, 1'b0);
    rd(1, 0);  chk("rs_c1", D_out, 1'b1);
    rd(4, 6);  chk("rs_c100", D_out, 1'b0);
    rd(15, 15); chk("rs_c255", D_out, 1'b1);
    Load_start = 1;
    tick;
    Load_start = 0;
    for (int i = 0; i < 128; i++) begin
      Load_valid = 1; Load_bit = 1;
      tick;
    end
    Load_valid = 0;
    RST = 1;
    #1;
    chk("mid_rst_dout", D_out, 1'b0);
    chk("mid_rst_ready", Ready, !scrub);
    chk("mid_rst_done", Load_done, 1'b0);
    tick;
    release_rst;
    pulses = 0;
    repeat (5) begin
      tick;
      pulses += Load_done;
    end
    chk("no_done_after_rst", pulses == 0, 1'b1);
    rd(0, 0);  chk("kept_c0", D_out, !scrub);
    rd(5, 9);  chk("kept_c149", D_out, !scrub);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
